// File: rtl/mole_game_controller.sv
// Whack-a-mole round controller: conditions the raw buttons, sequences IDLE/GAP/ACTIVE/HIT/OVER,
// picks mole positions from an LFSR and keeps a saturating score for combined_display.
module mole_game_controller #(
  parameter int         MOLE_TIME = 50_000_000,
  parameter int         GAP_TIME  = 10_000_000,
  parameter int         HIT_HOLD  = 25_000_000,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       pause_sw,
  input  logic [4:0] whack_btn,
  input  logic       timer_done,
  output logic [2:0] oval_select,
  output logic       enable,
  output logic       correctwhack,
  output logic [3:0] score,
  output logic       pause,
  output logic       game_over
);

  localparam int MAX_AB = (MOLE_TIME > GAP_TIME) ? MOLE_TIME : GAP_TIME;
  localparam int MAX_T  = (MAX_AB > HIT_HOLD) ? MAX_AB : HIT_HOLD;
  localparam int CNT_W  = $clog2(MAX_T);

  // Counters load N-1 and leave the state on the cycle they read zero, giving N cycles of dwell.
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_TIME - 1);
  localparam logic [CNT_W-1:0] MOLE_LD = CNT_W'(MOLE_TIME - 1);
  localparam logic [CNT_W-1:0] HIT_LD  = CNT_W'(HIT_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GAP    = 3'd1,
    S_ACTIVE = 3'd2,
    S_HIT    = 3'd3,
    S_OVER   = 3'd4
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       lfsr_q;
  logic [7:0]       lfsr_d;
  logic [2:0]       last_q;
  logic [2:0]       pick_d;

  logic       start_s1_q, start_s2_q, start_s3_q;
  logic       pause_s1_q, pause_s2_q;
  logic [4:0] whack_s1_q, whack_s2_q, whack_s3_q;

  logic       start_edge;
  logic [4:0] whack_edge;
  logic [4:0] hit_mask;
  logic       run_q;
  logic       frz;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'd15) ? v : v + 4'd1;
  endfunction

  // Never shows the same oval twice in a row: a repeat is bumped to the next oval, 5 wrapping to 1.
  function automatic logic [2:0] pick_oval(input logic [7:0] l, input logic [2:0] last);
    logic [2:0] c;
    c = 3'(l % 8'd5) + 3'd1;
    if (c == last) c = (c == 3'd5) ? 3'd1 : c + 3'd1;
    return c;
  endfunction

  // Input conditioning: two-flop synchronizers plus an edge-detect register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_s1_q <= 1'b0;
      start_s2_q <= 1'b0;
      start_s3_q <= 1'b0;
      pause_s1_q <= 1'b0;
      pause_s2_q <= 1'b0;
      whack_s1_q <= 5'd0;
      whack_s2_q <= 5'd0;
      whack_s3_q <= 5'd0;
    end else begin
      start_s1_q <= start_btn;
      start_s2_q <= start_s1_q;
      start_s3_q <= start_s2_q;
      pause_s1_q <= pause_sw;
      pause_s2_q <= pause_s1_q;
      whack_s1_q <= whack_btn;
      whack_s2_q <= whack_s1_q;
      whack_s3_q <= whack_s2_q;
    end
  end

  assign start_edge = start_s2_q & ~start_s3_q;
  assign whack_edge = whack_s2_q & ~whack_s3_q;
  assign run_q      = (state_q == S_GAP) || (state_q == S_ACTIVE) || (state_q == S_HIT);
  assign frz        = pause_s2_q & run_q;
  assign lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign pick_d     = pick_oval(lfsr_q, last_q);

  always_comb begin
    hit_mask = 5'd0;
    case (oval_select)
      3'd1:    hit_mask = 5'b00001;
      3'd2:    hit_mask = 5'b00010;
      3'd3:    hit_mask = 5'b00100;
      3'd4:    hit_mask = 5'b01000;
      3'd5:    hit_mask = 5'b10000;
      default: hit_mask = 5'd0;
    endcase
  end

  // Round state machine; every output is a register written alongside the state change
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      lfsr_q       <= LFSR_SEED;
      last_q       <= 3'd0;
      oval_select  <= 3'd0;
      enable       <= 1'b0;
      correctwhack <= 1'b0;
      score        <= 4'd0;
      pause        <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      // Mirrors s2(pause_sw) against the state being entered, so the output matches the internal freeze.
      pause  <= pause_s1_q & ((run_q & ~timer_done) | ((state_q == S_IDLE) & start_edge));

      case (state_q)
        S_IDLE: begin
          if (start_edge) begin
            state_q <= S_GAP;
            score   <= 4'd0;
            enable  <= 1'b1;
            cnt_q   <= GAP_LD;
          end
        end

        S_GAP, S_ACTIVE, S_HIT: begin
          if (timer_done) begin
            state_q      <= S_OVER;
            oval_select  <= 3'd0;
            enable       <= 1'b0;
            correctwhack <= 1'b0;
            game_over    <= 1'b1;
          end else if (!frz) begin
            case (state_q)
              S_GAP: begin
                if (cnt_q == '0) begin
                  state_q     <= S_ACTIVE;
                  oval_select <= pick_d;
                  last_q      <= pick_d;
                  cnt_q       <= MOLE_LD;
                end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
                end
              end

              S_ACTIVE: begin
                if (whack_edge != 5'd0) begin
                  if (whack_edge == hit_mask) begin
                    state_q      <= S_HIT;
                    correctwhack <= 1'b1;
                    score        <= sat_inc(score);
                    cnt_q        <= HIT_LD;
                  end else begin
                    state_q     <= S_GAP;
                    oval_select <= 3'd0;
                    cnt_q       <= GAP_LD;
                  end
                end else if (cnt_q == '0) begin
                  state_q     <= S_GAP;
                  oval_select <= 3'd0;
                  cnt_q       <= GAP_LD;
                end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
                end
              end

              default: begin
                if (cnt_q == '0) begin
                  state_q      <= S_GAP;
                  oval_select  <= 3'd0;
                  correctwhack <= 1'b0;
                  cnt_q        <= GAP_LD;
                end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
                end
              end
            endcase
          end
        end

        S_OVER: begin
          state_q <= S_OVER;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mole_game_controller.sv
// Randomized bench for mole_game_controller with a cycle-level behavioural game model.
module tb_mole_game_controller;

  localparam int MT = 20;
  localparam int GT = 4;
  localparam int HH = 5;

  localparam int PH_IDLE = 0;
  localparam int PH_GAP  = 1;
  localparam int PH_ACT  = 2;
  localparam int PH_HIT  = 3;
  localparam int PH_OVER = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_btn = 1'b0;
  logic       pause_sw = 1'b0;
  logic [4:0] whack_btn = 5'd0;
  logic       timer_done = 1'b0;
  logic [2:0] oval_select;
  logic       enable;
  logic       correctwhack;
  logic [3:0] score;
  logic       pause;
  logic       game_over;

  int checks = 0;
  int errors = 0;

  mole_game_controller #(
    .MOLE_TIME(MT), .GAP_TIME(GT), .HIT_HOLD(HH), .LFSR_SEED(8'hA5)
  ) dut (
    .clk(clk), .rst(rst), .start_btn(start_btn), .pause_sw(pause_sw),
    .whack_btn(whack_btn), .timer_done(timer_done), .oval_select(oval_select),
    .enable(enable), .correctwhack(correctwhack), .score(score),
    .pause(pause), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: raw-input history stands in for the synchronizers,
  // phase + cycles-left describes the round.
  int         m_phase, m_left, m_oval, m_last, m_score, cand;
  logic [7:0] m_lfsr, old_l;
  logic       m_pause;
  logic [6:0] h1, h2, h3;
  logic [4:0] ev;
  logic       st_e, p_s;

  function automatic bit is_run(input int ph);
    return (ph == PH_GAP) || (ph == PH_ACT) || (ph == PH_HIT);
  endfunction

  task automatic model_reset();
    m_phase = PH_IDLE; m_left = 0; m_oval = 0; m_last = 0; m_score = 0;
    m_lfsr = 8'hA5; m_pause = 1'b0; h1 = '0; h2 = '0; h3 = '0;
  endtask

  task automatic to_gap();
    m_phase = PH_GAP; m_left = GT; m_oval = 0;
  endtask

  task automatic model_step();
    ev   = h2[4:0] & ~h3[4:0];
    st_e = h2[6] & ~h3[6];
    p_s  = h2[5];
    old_l  = m_lfsr;
    m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
    if (m_phase == PH_IDLE) begin
      if (st_e) begin to_gap(); m_score = 0; end
    end else if (is_run(m_phase) && timer_done) begin
      m_phase = PH_OVER; m_oval = 0;
    end else if (is_run(m_phase) && !p_s) begin
      if (m_phase == PH_GAP) begin
        m_left--;
        if (m_left == 0) begin
          cand = int'(old_l) % 5 + 1;
          if (cand == m_last) cand = cand % 5 + 1;
          m_oval = cand; m_last = cand; m_phase = PH_ACT; m_left = MT;
        end
      end else if (m_phase == PH_ACT) begin
        if (ev != 5'd0) begin
          if (ev == 5'(1 << (m_oval - 1))) begin
            m_phase = PH_HIT; m_left = HH;
            if (m_score < 15) m_score++;
          end else begin
            to_gap();
          end
        end else begin
          m_left--;
          if (m_left == 0) to_gap();
        end
      end else begin
        m_left--;
        if (m_left == 0) to_gap();
      end
    end
    m_pause = h1[5] && is_run(m_phase);
    h3 = h2; h2 = h1; h1 = {start_btn, pause_sw, whack_btn};
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else model_step();
  end

  // Per-cycle comparison plus spawn tracking (no oval repeats back-to-back)
  int prev_oval = 0;
  int last_spawn = 0;
  int spawn_cnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_oval  = 0;
      last_spawn = 0;
    end else begin
      chk("oval_select", int'(oval_select), m_oval);
      chk("enable", int'(enable), int'(is_run(m_phase)));
      chk("correctwhack", int'(correctwhack), int'(m_phase == PH_HIT));
      chk("score", int'(score), m_score);
      chk("pause", int'(pause), int'(m_pause));
      chk("game_over", int'(game_over), int'(m_phase == PH_OVER));
      if (prev_oval == 0 && oval_select != 3'd0) begin
        chk("oval_range", int'(oval_select >= 3'd1 && oval_select <= 3'd5), 1);
        if (last_spawn != 0) chk("consecutive_differ", int'(int'(oval_select) != last_spawn), 1);
        last_spawn = int'(oval_select);
        spawn_cnt++;
      end
      prev_oval = int'(oval_select);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_whack(input logic [4:0] v);
    whack_btn = v;
    tick(1);
    whack_btn = 5'd0;
  endtask

  task automatic pulse_start();
    start_btn = 1'b1;
    tick(1);
    start_btn = 1'b0;
  endtask

  task automatic wait_fresh(output int ov);
    int n;
    n = 0;
    while (oval_select != 3'd0 && n < 200) begin tick(1); n++; end
    while (oval_select == 3'd0 && n < 200) begin tick(1); n++; end
    ov = int'(oval_select);
    chk("wait_fresh_mole", int'(ov != 0), 1);
    if (ov == 0) ov = 1;
  endtask

  function automatic logic [4:0] mask_of(input int ov);
    return 5'(1 << (ov - 1));
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int ov, n;
    logic [4:0] rnd;

    tick(2);
    chk("rst_oval", int'(oval_select), 0);
    chk("rst_enable", int'(enable), 0);
    chk("rst_correctwhack", int'(correctwhack), 0);
    chk("rst_score", int'(score), 0);
    chk("rst_pause", int'(pause), 0);
    chk("rst_game_over", int'(game_over), 0);
    chk("model_seed", int'(m_lfsr), 8'hA5);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("model_lfsr_step1", int'(m_lfsr), 8'h4A);
    @(negedge clk);

    pulse_start();
    tick(3);
    chk("start_enable", int'(enable), 1);
    chk("start_gap_oval", int'(oval_select), 0);

    for (int i = 0; i < 3000 && spawn_cnt < 50; i++) tick(1);
    chk("fifty_spawns", int'(spawn_cnt >= 50), 1);

    for (int k = 0; k < 3; k++) begin
      wait_fresh(ov);
      pulse_whack(mask_of(ov));
      tick(2);
      chk("hit_correctwhack", int'(correctwhack), 1);
      chk("hit_score", int'(score), k + 1);
    end

    wait_fresh(ov);
    tick(5);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_oval", int'(oval_select), 0);
    chk("async_rst_score", int'(score), 0);
    chk("async_rst_enable", int'(enable), 0);
    tick(2);
    rst = 1'b0;
    tick(1);

    pulse_start();
    tick(3);
    wait_fresh(ov);
    pulse_whack(mask_of(ov % 5 + 1));
    tick(2);
    chk("wrong_btn_oval", int'(oval_select), 0);
    chk("wrong_btn_cw", int'(correctwhack), 0);
    chk("wrong_btn_score", int'(score), 0);
    wait_fresh(ov);
    pulse_whack(mask_of(ov) | mask_of(ov % 5 + 1));
    tick(2);
    chk("multi_btn_oval", int'(oval_select), 0);
    chk("multi_btn_cw", int'(correctwhack), 0);
    chk("multi_btn_score", int'(score), 0);

    for (int i = 0; i < 800; i++) begin
      whack_btn = 5'd0;
      n = int'($urandom_range(0, 19));
      if (n == 0 && oval_select != 3'd0) whack_btn = mask_of(int'(oval_select));
      else if (n == 1) begin rnd = 5'($urandom); whack_btn = rnd; end
      if ($urandom_range(0, 39) == 0) pause_sw = ~pause_sw;
      start_btn = ($urandom_range(0, 49) == 0);
      tick(1);
    end
    whack_btn = 5'd0; pause_sw = 1'b0; start_btn = 1'b0;
    tick(5);

    for (int k = 0; k < 17; k++) begin
      wait_fresh(ov);
      pulse_whack(mask_of(ov));
      tick(2);
    end
    chk("score_saturated", int'(score), 15);

    wait_fresh(ov);
    tick(7);
    pause_sw = 1'b1;
    for (int i = 0; i < 100; i++) begin
      whack_btn = (i % 30 == 15) ? mask_of(ov) : 5'd0;
      if (i == 50) begin
        chk("pause_high", int'(pause), 1);
        chk("pause_oval_frozen", int'(oval_select), ov);
        chk("pause_no_hit", int'(correctwhack), 0);
      end
      tick(1);
    end
    whack_btn = 5'd0;
    pause_sw = 1'b0;
    n = 0;
    while (oval_select != 3'd0 && n < 50) begin tick(1); n++; end
    chk("pause_remaining_dwell", n, 13);

    wait_fresh(ov);
    whack_btn = mask_of(ov);
    tick(1);
    whack_btn = 5'd0;
    tick(1);
    timer_done = 1'b1;
    tick(1);
    chk("over_game_over", int'(game_over), 1);
    chk("over_enable", int'(enable), 0);
    chk("over_oval", int'(oval_select), 0);
    chk("over_cw", int'(correctwhack), 0);
    pulse_start();
    tick(5);
    chk("over_start_ignored", int'(game_over), 1);
    chk("over_start_enable", int'(enable), 0);
    tick(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
